// File: rtl/loop_bfr_rply.sv
// loop_bfr_rply: forwards fetch packets, captures a detected loop body and replays it while fetch stalls.
// Optional per-slot PC storage is built when LOOP_BFR_RPLY_PC_EN is defined; otherwise pc_out is tied to 0.
module loop_bfr_rply #(
   parameter int DEPTH = 64,
   parameter int CW    = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] inst_in,
   input  logic [63:0] pc_in,
   input  logic        loop_strt_in,
   input  logic [3:0]  inst_valid_in,
   input  logic        stll_ftch_in,
   input  logic        fnsh_unrll_in,
   input  logic        mis_pred_in,
   output logic [63:0] inst_out,
   output logic [63:0] pc_out,
   output logic [3:0]  inst_valid_out,
   output logic        rply_actv_out,
   output logic        rply_done_out,
   output logic        ovfl_out
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      CAPTURE = 2'b01,
      REPLAY  = 2'b10
   } state_t;

   state_t        r_state, w_state_next;
   logic [CW-1:0] r_wr_ptr, w_wr_ptr_next;
   logic [CW-1:0] r_rd_ptr, w_rd_ptr_next;
   logic [CW-1:0] r_body_len, w_body_len_next;
   logic          r_fnsh_pend, w_fnsh_pend_next;

   logic [15:0]   r_ibuf [DEPTH];

   logic [CW-1:0] w_n, w_m, w_rem, w_wr_end, w_rd_end;
   logic          w_cap, w_wr_en, w_ovfl, w_wrap, w_done;
   logic [3:0]    w_rply_mask;
   logic [63:0]   w_rply_inst;

   logic [63:0]   r_inst_out;
   logic [3:0]    r_valid_out;
   logic          r_actv, r_done, r_ovfl;

   // Lane count of the incoming packet (masks are always leading ones)
   always_comb begin
      w_n = CW'(4);
      case (inst_valid_in)
         4'b1000: w_n = CW'(1);
         4'b1100: w_n = CW'(2);
         4'b1110: w_n = CW'(3);
         default: w_n = CW'(4);
      endcase
   end

   assign w_cap    = !mis_pred_in && !stll_ftch_in &&
                     ((r_state == IDLE && loop_strt_in) || r_state == CAPTURE);
   assign w_wr_end = r_wr_ptr + w_n;
   assign w_ovfl   = w_cap && (w_wr_end > CW'(DEPTH));
   assign w_wr_en  = w_cap && !w_ovfl;

   // A replay packet never crosses the end of the body
   assign w_rem    = r_body_len - r_rd_ptr;
   assign w_m      = (w_rem > CW'(4)) ? CW'(4) : w_rem;
   assign w_rd_end = r_rd_ptr + w_m;
   assign w_wrap   = (r_state == REPLAY) && (w_rd_end == r_body_len);
   assign w_done   = w_wrap && (r_fnsh_pend || fnsh_unrll_in) && !mis_pred_in;

   always_comb begin
      w_rply_mask = 4'b0000;
      case (w_m)
         CW'(1):  w_rply_mask = 4'b1000;
         CW'(2):  w_rply_mask = 4'b1100;
         CW'(3):  w_rply_mask = 4'b1110;
         CW'(4):  w_rply_mask = 4'b1111;
         default: w_rply_mask = 4'b0000;
      endcase
   end

`ifdef LOOP_BFR_RPLY_PC_EN
   logic [15:0] r_pbuf [DEPTH];
   logic [63:0] w_rply_pc;
   logic [63:0] r_pc_out;
`endif

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [AW-1:0] w_rd_idx;
      assign w_rd_idx = AW'(r_rd_ptr + CW'(gi));
      assign w_rply_inst[63-16*gi -: 16] = (CW'(gi) < w_m) ? r_ibuf[w_rd_idx] : 16'h0000;
`ifdef LOOP_BFR_RPLY_PC_EN
      assign w_rply_pc[63-16*gi -: 16] = (CW'(gi) < w_m) ? r_pbuf[w_rd_idx] : 16'h0000;
`endif
   end

   // Buffer storage is intentionally left out of reset
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (CW'(i) < w_n) begin
               r_ibuf[AW'(r_wr_ptr + CW'(i))] <= inst_in[63-16*i -: 16];
`ifdef LOOP_BFR_RPLY_PC_EN
               r_pbuf[AW'(r_wr_ptr + CW'(i))] <= pc_in[63-16*i -: 16];
`endif
            end
         end
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_wr_ptr_next    = r_wr_ptr;
      w_rd_ptr_next    = r_rd_ptr;
      w_body_len_next  = r_body_len;
      w_fnsh_pend_next = r_fnsh_pend;
      if (mis_pred_in) begin
         w_state_next     = IDLE;
         w_wr_ptr_next    = '0;
         w_rd_ptr_next    = '0;
         w_fnsh_pend_next = 1'b0;
      end else begin
         case (r_state)
            IDLE, CAPTURE: begin
               if (r_state == IDLE && loop_strt_in) w_state_next = CAPTURE;
               if (w_ovfl) begin
                  w_state_next  = IDLE;
                  w_wr_ptr_next = '0;
               end else if (w_wr_en) begin
                  if (inst_valid_in != 4'b1111) begin
                     w_body_len_next = w_wr_end;
                     w_rd_ptr_next   = '0;
                     w_state_next    = REPLAY;
                  end else begin
                     w_wr_ptr_next = w_wr_end;
                  end
               end
            end
            REPLAY: begin
               if (w_done) begin
                  w_state_next     = IDLE;
                  w_wr_ptr_next    = '0;
                  w_rd_ptr_next    = '0;
                  w_fnsh_pend_next = 1'b0;
               end else begin
                  w_rd_ptr_next    = w_wrap ? '0 : w_rd_end;
                  w_fnsh_pend_next = r_fnsh_pend | fnsh_unrll_in;
               end
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_body_len  <= '0;
         r_fnsh_pend <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_wr_ptr    <= w_wr_ptr_next;
         r_rd_ptr    <= w_rd_ptr_next;
         r_body_len  <= w_body_len_next;
         r_fnsh_pend <= w_fnsh_pend_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inst_out  <= '0;
         r_valid_out <= '0;
         r_actv      <= 1'b0;
         r_done      <= 1'b0;
         r_ovfl      <= 1'b0;
      end else begin
         r_actv <= (w_state_next == REPLAY);
         r_done <= w_done;
         r_ovfl <= w_ovfl;
         if (r_state == REPLAY) begin
            r_inst_out  <= w_rply_inst;
            r_valid_out <= mis_pred_in ? 4'b0000 : w_rply_mask;
         end else begin
            r_inst_out  <= inst_in;
            r_valid_out <= (stll_ftch_in || mis_pred_in) ? 4'b0000 : inst_valid_in;
         end
      end
   end

`ifdef LOOP_BFR_RPLY_PC_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pc_out <= '0;
      else     r_pc_out <= (r_state == REPLAY) ? w_rply_pc : pc_in;
   end
   assign pc_out = r_pc_out;
`else
   logic w_unused_pc;
   assign w_unused_pc = ^pc_in;
   assign pc_out      = '0;
`endif

   assign inst_out       = r_inst_out;
   assign inst_valid_out = r_valid_out;
   assign rply_actv_out  = r_actv;
   assign rply_done_out  = r_done;
   assign ovfl_out       = r_ovfl;
endmodule

// File: tb/tb_loop_bfr_rply.sv
// Bench for loop_bfr_rply: expected outputs are queued as each cycle's stimulus is driven and
// compared one cycle later; PC expectations follow LOOP_BFR_RPLY_PC_EN.
module tb_loop_bfr_rply;
   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] inst_in, pc_in;
   logic        loop_strt_in, stll_ftch_in, fnsh_unrll_in, mis_pred_in;
   logic [3:0]  inst_valid_in;
   logic [63:0] inst_out, pc_out;
   logic [3:0]  inst_valid_out;
   logic        rply_actv_out, rply_done_out, ovfl_out;

   loop_bfr_rply #(.DEPTH(64), .CW(7)) dut (
      .clk(clk), .rst(rst),
      .inst_in(inst_in), .pc_in(pc_in),
      .loop_strt_in(loop_strt_in), .inst_valid_in(inst_valid_in),
      .stll_ftch_in(stll_ftch_in), .fnsh_unrll_in(fnsh_unrll_in),
      .mis_pred_in(mis_pred_in),
      .inst_out(inst_out), .pc_out(pc_out), .inst_valid_out(inst_valid_out),
      .rply_actv_out(rply_actv_out), .rply_done_out(rply_done_out), .ovfl_out(ovfl_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] inst;
      logic [63:0] pc;
      logic [3:0]  v;
      logic        actv;
      logic        done;
      logic        ovfl;
      logic        chk_inst;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  g_tag;
   logic [15:0] body_inst [64];
   logic [15:0] body_pc   [64];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] ival(input int slot);
      return {g_tag, g_tag ^ 8'(slot)};
   endfunction

   function automatic logic [3:0] lead(input int n);
      logic [3:0] r;
      r = 4'b0000;
      for (int i = 0; i < n; i++) r[3-i] = 1'b1;
      return r;
   endfunction

   function automatic exp_t pass_exp(input logic [3:0] v, input logic actv, input logic ovfl);
      exp_t e;
      e.inst = inst_in;
`ifdef LOOP_BFR_RPLY_PC_EN
      e.pc = pc_in;
`else
      e.pc = 64'h0;
`endif
      e.v = v; e.actv = actv; e.done = 1'b0; e.ovfl = ovfl; e.chk_inst = 1'b1;
      return e;
   endfunction

   function automatic exp_t rply_exp(input int start, input int len, input logic actv, input logic done);
      exp_t e;
      int   m;
      m = (len - start > 4) ? 4 : len - start;
      e.inst = 64'h0; e.pc = 64'h0; e.v = 4'b0000;
      for (int i = 0; i < m; i++) begin
         e.inst[63-16*i -: 16] = body_inst[start+i];
`ifdef LOOP_BFR_RPLY_PC_EN
         e.pc[63-16*i -: 16] = body_pc[start+i];
`endif
         e.v[3-i] = 1'b1;
      end
      e.actv = actv; e.done = done; e.ovfl = 1'b0; e.chk_inst = 1'b1;
      return e;
   endfunction

   task automatic set_idle();
      stll_ftch_in  = 1'b1;
      loop_strt_in  = 1'b0;
      mis_pred_in   = 1'b0;
      fnsh_unrll_in = 1'b0;
      inst_valid_in = 4'b1111;
      inst_in       = {$urandom, $urandom};
      pc_in         = {$urandom, $urandom};
   endtask

   task automatic step(input exp_t e);
      exp_t x;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      $display("t=%0t inst=%h pc=%h v=%b actv=%b done=%b ovfl=%b", $time,
               inst_out, pc_out, inst_valid_out, rply_actv_out, rply_done_out, ovfl_out);
      chk("valid", 64'(inst_valid_out), 64'(x.v));
      chk("actv",  64'(rply_actv_out),  64'(x.actv));
      chk("done",  64'(rply_done_out),  64'(x.done));
      chk("ovfl",  64'(ovfl_out),       64'(x.ovfl));
      if (x.chk_inst) begin
         chk("inst", inst_out, x.inst);
         chk("pc",   pc_out,   x.pc);
      end
   endtask

   // Drives one non-stalled fetch packet of n lanes whose first lane lands in slot
   task automatic cap_pkt(input int slot, input int n, input logic strt, input logic actv, input logic ovfl);
      stll_ftch_in  = 1'b0;
      loop_strt_in  = strt;
      mis_pred_in   = 1'b0;
      fnsh_unrll_in = 1'b0;
      inst_valid_in = lead(n);
      for (int i = 0; i < 4; i++) begin
         inst_in[63-16*i -: 16] = (i < n) ? ival(slot + i) : (16'hDEA0 | 16'(i));
         pc_in[63-16*i -: 16]   = (i < n) ? 16'(16'h0100 + slot + i) : (16'hBEE0 | 16'(i));
         if (i < n && !ovfl) begin
            body_inst[slot+i] = ival(slot + i);
            body_pc[slot+i]   = 16'(16'h0100 + slot + i);
         end
      end
      step(pass_exp(lead(n), actv, ovfl));
   endtask

   task automatic replay(input int len, input int n_iter, input int fnsh_iter, input int fnsh_pkt);
      int  rd, pkt, m;
      logic last;
      for (int it = 0; it < n_iter; it++) begin
         rd = 0; pkt = 0;
         while (rd < len) begin
            m = (len - rd > 4) ? 4 : len - rd;
            last = (it == n_iter - 1) && (rd + m == len);
            set_idle();
            fnsh_unrll_in = (it == fnsh_iter) && (pkt == fnsh_pkt);
            step(rply_exp(rd, len, !last, last));
            rd += m; pkt++;
         end
      end
   endtask

   task automatic idle_step();
      set_idle();
      step(pass_exp(4'b0000, 1'b0, 1'b0));
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      set_idle();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_inst",  inst_out, 64'h0);
      chk("rst_pc",    pc_out, 64'h0);
      chk("rst_valid", 64'(inst_valid_out), 64'h0);
      chk("rst_actv",  64'(rply_actv_out), 64'h0);
      chk("rst_done",  64'(rply_done_out), 64'h0);
      chk("rst_ovfl",  64'(ovfl_out), 64'h0);

      // Basic 10-instruction body, finish pulsed mid third iteration
      g_tag = 8'h11;
      cap_pkt(0, 4, 1'b1, 1'b0, 1'b0);
      cap_pkt(4, 4, 1'b0, 1'b0, 1'b0);
      cap_pkt(8, 2, 1'b0, 1'b1, 1'b0);
      replay(10, 3, 2, 1);
      idle_step();

      // Single-lane body
      g_tag = 8'hA5;
      cap_pkt(0, 1, 1'b1, 1'b1, 1'b0);
      replay(1, 1, 0, 0);
      idle_step();

      // Overflow on the 17th full packet, then recapture from slot 0
      g_tag = 8'h33;
      for (int k = 0; k < 16; k++) cap_pkt(4*k, 4, (k == 0), 1'b0, 1'b0);
      cap_pkt(64, 4, 1'b0, 1'b0, 1'b1);
      idle_step();
      g_tag = 8'h44;
      cap_pkt(0, 1, 1'b1, 1'b1, 1'b0);
      replay(1, 1, 0, 0);
      idle_step();

      // Fetch stall during capture
      g_tag = 8'h55;
      cap_pkt(0, 4, 1'b1, 1'b0, 1'b0);
      idle_step();
      idle_step();
      cap_pkt(4, 3, 1'b0, 1'b1, 1'b0);
      replay(7, 2, 1, 0);
      idle_step();

      // Misprediction at rd_ptr=4, then recapture from slot 0
      g_tag = 8'h66;
      cap_pkt(0, 4, 1'b1, 1'b0, 1'b0);
      cap_pkt(4, 4, 1'b0, 1'b0, 1'b0);
      cap_pkt(8, 2, 1'b0, 1'b1, 1'b0);
      set_idle();
      step(rply_exp(0, 10, 1'b1, 1'b0));
      begin
         exp_t e;
         set_idle();
         mis_pred_in = 1'b1;
         e = rply_exp(4, 10, 1'b0, 1'b0);
         e.v = 4'b0000;
         e.chk_inst = 1'b0;
         step(e);
      end
      idle_step();
      g_tag = 8'h77;
      cap_pkt(0, 2, 1'b1, 1'b1, 1'b0);
      replay(2, 2, 1, 0);
      idle_step();

      // PC path: PCs 0100..0105
      g_tag = 8'h88;
      cap_pkt(0, 4, 1'b1, 1'b0, 1'b0);
      cap_pkt(4, 2, 1'b0, 1'b1, 1'b0);
      replay(6, 2, 1, 1);
      idle_step();

      // Asynchronous reset in the middle of replay
      g_tag = 8'h99;
      cap_pkt(0, 4, 1'b1, 1'b0, 1'b0);
      cap_pkt(4, 1, 1'b0, 1'b1, 1'b0);
      set_idle();
      step(rply_exp(0, 5, 1'b1, 1'b0));
      rst = 1'b1;
      #1;
      chk("arst_valid", 64'(inst_valid_out), 64'h0);
      chk("arst_inst",  inst_out, 64'h0);
      chk("arst_actv",  64'(rply_actv_out), 64'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle_step();

      chk("queue_empty", 64'(exp_q.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
